pwm_gen: RTL

- Output stage of the PPWM channel: a free-running period counter with prescaler, period-start generation, a duty shadow register and the PWM pin driver.
- Feeds `start_i` and `global_counter_i` to the execution unit.
- Consumes the execution unit's `pwm_value_o` and latches it once per period, so program updates never glitch the active period.

---
 rtl/pwm_gen_if.sv | 27 ++
 rtl/pwm_gen.sv | 155 +++++++++++++++
 2 files changed

// File: rtl/pwm_gen_if.sv
// pwm_gen_if: channel-side signal bundle for the PWM output stage.
// slave  = the pwm_gen block, master = whoever drives enable/config/duty.
interface pwm_gen_if #(
    parameter int COUNTER_WIDTH  = 8,
    parameter int PRESCALE_WIDTH = 4,
    parameter int DEADTIME_WIDTH = 3
);
    logic                      enable_i;
    logic [PRESCALE_WIDTH-1:0] prescale_i;
    logic [DEADTIME_WIDTH-1:0] deadtime_i;
    logic [COUNTER_WIDTH-1:0]  pwm_value_i;
    logic                      start_o;
    logic [COUNTER_WIDTH-1:0]  global_counter_o;
    logic [COUNTER_WIDTH-1:0]  duty_o;
    logic                      pwm_o;
    logic                      pwm_n_o;

    modport slave (
        input  enable_i, prescale_i, deadtime_i, pwm_value_i,
        output start_o, global_counter_o, duty_o, pwm_o, pwm_n_o
    );

    modport master (
        output enable_i, prescale_i, deadtime_i, pwm_value_i,
        input  start_o, global_counter_o, duty_o, pwm_o, pwm_n_o
    );
endinterface

// File: rtl/pwm_gen.sv
// pwm_gen: PWM output stage. Free-running period counter with prescaler,
// period-start pulse, per-period duty/prescale shadow latch and pin driver.
// All outputs are registered from next-state values so pwm_o lines up with
// global_counter_o. Optional dead-time insertion on pwm_o/pwm_n_o is built
// only when PPWM_DEADTIME_EN is defined.
module pwm_gen #(
    parameter int COUNTER_WIDTH  = 8,
    parameter int PRESCALE_WIDTH = 4,
    parameter int DEADTIME_WIDTH = 3
) (
    input  logic     clk,
    input  logic     rst_n,
    pwm_gen_if.slave bus
);

    typedef enum logic {StOff, StRun} state_e;

    state_e                    state_q, state_d;
    logic [COUNTER_WIDTH-1:0]  cnt_q, cnt_d;
    logic [PRESCALE_WIDTH-1:0] presc_cnt_q, presc_cnt_d;
    logic [PRESCALE_WIDTH-1:0] presc_q, presc_d;
    logic [COUNTER_WIDTH-1:0]  duty_q, duty_d;
    logic                      start_q, start_d;
    logic                      pwm_q, pwm_d;
    logic                      pwm_n_q, pwm_n_d;
    logic                      raw_p, raw_n;
    logic                      tick;

    // Next-state: FSM, prescaler, counter and shadow latches. Entry into
    // StRun and the wrapping tick both start a new period (start_d high).
    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        presc_cnt_d = presc_cnt_q;
        presc_d     = presc_q;
        duty_d      = duty_q;
        start_d     = 1'b0;
        tick        = 1'b0;
        raw_p       = 1'b0;
        raw_n       = 1'b0;
        case (state_q)
            StOff: begin
                cnt_d       = '0;
                presc_cnt_d = '0;
                duty_d      = '0;
                if (bus.enable_i) begin
                    state_d = StRun;
                    duty_d  = bus.pwm_value_i;
                    presc_d = bus.prescale_i;
                    start_d = 1'b1;
                end
            end
            StRun: begin
                if (!bus.enable_i) begin
                    // Disable wins over a coinciding wrap: no start pulse.
                    state_d     = StOff;
                    cnt_d       = '0;
                    presc_cnt_d = '0;
                    duty_d      = '0;
                end else begin
                    tick = (presc_cnt_q == presc_q);
                    if (tick) begin
                        presc_cnt_d = '0;
                        cnt_d       = cnt_q + COUNTER_WIDTH'(1);
                        if (cnt_q == '1) begin
                            duty_d  = bus.pwm_value_i;
                            presc_d = bus.prescale_i;
                            start_d = 1'b1;
                        end
                    end else begin
                        presc_cnt_d = presc_cnt_q + PRESCALE_WIDTH'(1);
                    end
                end
            end
            default: state_d = StOff;
        endcase
        // Raw complementary pair, evaluated on next-state values.
        if (state_d == StRun) begin
            raw_p = (cnt_d < duty_d);
            raw_n = ~raw_p;
        end
    end

`ifdef PPWM_DEADTIME_EN
    // Run-length counters: how many consecutive cycles each raw output has
    // been high, saturating above the largest possible dead-time.
    logic [DEADTIME_WIDTH-1:0] dt_q, dt_d;
    logic [DEADTIME_WIDTH:0]   run_p_q, run_p_d;
    logic [DEADTIME_WIDTH:0]   run_n_q, run_n_d;

    // Dead-time: a raw high shows on the pin only once it has lasted more
    // than dt cycles, so rising edges are delayed and short pulses vanish.
    always_comb begin
        dt_d    = start_d ? bus.deadtime_i : dt_q;
        run_p_d = '0;
        run_n_d = '0;
        if (raw_p) run_p_d = (run_p_q == '1) ? run_p_q : run_p_q + (DEADTIME_WIDTH+1)'(1);
        if (raw_n) run_n_d = (run_n_q == '1) ? run_n_q : run_n_q + (DEADTIME_WIDTH+1)'(1);
        pwm_d   = raw_p && (run_p_d > {1'b0, dt_d});
        pwm_n_d = raw_n && (run_n_d > {1'b0, dt_d});
    end

    // Dead-time state registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            dt_q    <= '0;
            run_p_q <= '0;
            run_n_q <= '0;
        end else begin
            dt_q    <= dt_d;
            run_p_q <= run_p_d;
            run_n_q <= run_n_d;
        end
    end
`else
    logic unused_deadtime;
    assign unused_deadtime = ^bus.deadtime_i;

    // Without dead-time the pins follow the raw pair directly.
    always_comb begin
        pwm_d   = raw_p;
        pwm_n_d = raw_n;
    end
`endif

    // State and output registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= StOff;
            cnt_q       <= '0;
            presc_cnt_q <= '0;
            presc_q     <= '0;
            duty_q      <= '0;
            start_q     <= 1'b0;
            pwm_q       <= 1'b0;
            pwm_n_q     <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            presc_cnt_q <= presc_cnt_d;
            presc_q     <= presc_d;
            duty_q      <= duty_d;
            start_q     <= start_d;
            pwm_q       <= pwm_d;
            pwm_n_q     <= pwm_n_d;
        end
    end

    assign bus.start_o          = start_q;
    assign bus.global_counter_o = cnt_q;
    assign bus.duty_o           = duty_q;
    assign bus.pwm_o            = pwm_q;
    assign bus.pwm_n_o          = pwm_n_q;

endmodule
